// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the memory side of mem_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between an instruction fetch port and a data port,
// with a fixed read latency and a bounded run of data grants while a fetch waits.
module mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int STREAK  = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);
    localparam logic [2:0] STK = 3'(STREAK);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [2:0] streak, streak_nxt;
    logic       owner, owner_nxt;   // 0 = fetch, 1 = data
    logic       store, store_nxt;   // outstanding data access is a store
    logic       respond, free, grant_d, grant_f;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values; blocking here would create order-dependent races.
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            streak <= '0;
            owner  <= 1'b0;
            store  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            streak <= streak_nxt;
            owner  <= owner_nxt;
            store  <= store_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block
        // leaves one unassigned and no latch is inferred.
        state_nxt     = state;
        cnt_nxt       = cnt;
        streak_nxt    = streak;
        owner_nxt     = owner;
        store_nxt     = store;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = 1'b0;

        respond = (state == S_WAIT) && (cnt == LAT);
        free    = (state == S_IDLE) || respond;
        // Data wins ties until it has used up its streak against a waiting fetch.
        grant_d = free && bus.d_req && (!bus.if_req || (streak < STK));
        grant_f = free && bus.if_req && !grant_d;

        if (!reset) begin
            bus.if_gnt = grant_f;
            bus.d_gnt  = grant_d;

            if (grant_d) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.d_we;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
            end else if (grant_f) begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = bus.if_addr;
            end

            if (respond) begin
                if (owner) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = store ? 16'h0000 : bus.mem_rdata;
                end else begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.mem_rdata;
                end
            end

            bus.busy = ((state == S_WAIT) && (cnt < LAT)) ||
                       (bus.if_req && !grant_f) || (bus.d_req && !grant_d);
        end

        if (state == S_WAIT) begin
            if (cnt < LAT) begin
                cnt_nxt = cnt + 3'd1;
            end else begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        end

        if (grant_d) begin
            state_nxt  = S_WAIT;
            cnt_nxt    = 3'd1;
            owner_nxt  = 1'b1;
            store_nxt  = bus.d_we;
            streak_nxt = !bus.if_req ? 3'd0 : (streak == 3'd7) ? streak : streak + 3'd1;
        end else if (grant_f) begin
            state_nxt  = S_WAIT;
            cnt_nxt    = 3'd1;
            owner_nxt  = 1'b0;
            store_nxt  = 1'b0;
            streak_nxt = '0;
        end
    end

endmodule
